mux_pipe_nw: RTL
================

Name: mux_pipe_nw

Overview:
- Registered, flow-controlled N:1 selector of W-bit values; parametrised successor of the 2:1 5-bit selector used in the datapath.
- Sits at pipeline-stage boundaries, e.g. register-destination select (rt/rd/$31/$0) into ID/EX and forwarding-operand select into EX/MEM.
- Adds a one-cycle output register, valid/ready handshake with a 1-entry skid buffer, synchronous flush, and out-of-range select detection.

Parameters:
- WIDTH, 5, data width of each input lane and of the output.
- NUM_IN, 4, number of input lanes (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- DEFAULT_VAL, 0, WIDTH-bit value driven when the select is out of range.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_bus  in  NUM_IN*WIDTH  packed lanes; lane i = in_bus[i*WIDTH +: WIDTH].
- sel  in  SEL_W  lane select, sampled with the input beat.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat (registered).
- out_data  out  WIDTH  selected value (registered).
- out_sel  out  SEL_W  select that produced out_data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts a beat.
- flush  in  1  synchronous kill of all held beats.
- sel_err  out  1  sticky flag: an out-of-range sel was accepted.
- err_clr  in  1  synchronous clear of sel_err.

Behaviour:
- Reset (rst_n=0, async) sets: out_data=0, out_sel=0, out_valid=0, skid empty, in_ready=1, sel_err=0. Reset mid-transfer discards every held beat.
- Accept condition: in_valid && in_ready at a rising edge.
- Emit condition: out_valid && out_ready at a rising edge.
- Select:
  - sel < NUM_IN gives in_bus lane sel.
  - sel >= NUM_IN gives DEFAULT_VAL, and sets sel_err on accept.
  - Select is evaluated on the accept cycle. Later changes to in_bus or sel do not affect captured beats.
- Latency: an accepted beat appears on out_data/out_valid the next cycle when the output register is free. Throughput is 1 beat per cycle while out_ready=1.
- Storage: output register plus one skid entry (2 beats max).
  - in_ready = !skid_full, registered.
  - Output empty, or emitting this cycle: the accepted beat loads the output register.
  - Output full and not emitting: the accepted beat loads the skid; in_ready drops the next cycle.
  - Emit with skid full: skid moves to the output register; in_ready returns to 1 the next cycle.
  - Emit with nothing to replace it: out_valid=0 the next cycle.
- Out_data and out_sel hold stable while out_valid=1 and out_ready=0. They are not cleared on emit.
- Flush (highest priority after reset):
  - Next cycle: out_valid=0, skid empty, in_ready=1.
  - A beat offered in the flush cycle is dropped even if in_ready=1.
  - An emit in the same cycle still completes downstream. The block does not roll it back.
- sel_err:
  - Set by an accepted bad select.
  - Cleared by err_clr.
  - Set and clear in the same cycle: set wins.
  - sel_err is not cleared by flush.
- Width rules: no arithmetic; lanes pass bit-exact. SEL_W bits above what NUM_IN needs are still compared, so sel=2**SEL_W-1 with NUM_IN<2**SEL_W is an error.

Test Plan:
- Streaming: WIDTH=5, NUM_IN=4, out_ready=1; lanes {0x03,0x0A,0x1F,0x11}; sel 0,1,2,3 on consecutive cycles -> out_data 0x03,0x0A,0x1F,0x11 one cycle later each, out_valid held 1, in_ready always 1.
- Backpressure: out_ready=0 after the first beat; offer sel=1 then sel=2 -> out_data=0x0A holds, skid captures 0x1F, in_ready=0 the following cycle. out_ready=1 for 2 cycles -> 0x0A then 0x1F emitted, in_ready returns to 1, no beat lost or duplicated.
- Bad select: NUM_IN=3, SEL_W=2, DEFAULT_VAL=0x1F; accept sel=3 -> out_data=0x1F, out_sel=3, sel_err=1 and sticky. err_clr pulse -> 0. err_clr together with another bad-sel accept -> sel_err stays 1.
- Flush: output and skid both full; flush=1 while in_valid=1 -> next cycle out_valid=0, in_ready=1, the offered beat is never emitted, sel_err unchanged.
- Async reset: assert rst_n=0 mid-cycle with 2 beats held -> outputs reach reset values immediately without a clock edge. Release -> first accepted beat emits after 1 cycle.
- Parameter sweep: WIDTH=32, NUM_IN=2, SEL_W=1 -> equals a plain 2:1 select delayed by one register. Random valid/ready traffic is checked against a scoreboard for order and values.

Source files
------------

// File: rtl/mux_pipe_nw.sv
// Registered N:1 lane selector with valid/ready flow control, a one-entry skid buffer,
// synchronous flush and a sticky out-of-range select flag.
module mux_pipe_nw #(
    parameter int               WIDTH       = 5,
    parameter int               NUM_IN      = 4,
    parameter int               SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic                    sel_err,
    input  logic                    err_clr
);

    logic [WIDTH-1:0] lane_data;
    logic             sel_hit;

    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_sel_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] skid_data_r;
    logic [SEL_W-1:0] skid_sel_r;
    logic             skid_valid_r;
    logic             in_ready_r;
    logic             sel_err_r;

    logic accept;
    logic emit;
    logic load_from_skid;
    logic load_from_in;
    logic load_skid;
    logic out_valid_n;
    logic skid_valid_n;

    // Every select value is compared in full, so unused codes above NUM_IN-1 fall through
    // to DEFAULT_VAL and leave sel_hit low.
    // NOTE: every always_comb output gets a default before any condition, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        lane_data = DEFAULT_VAL;
        sel_hit   = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                lane_data = in_bus[i*WIDTH +: WIDTH];
                sel_hit   = 1'b1;
            end
        end
    end

    // in_ready_r always mirrors !skid_valid_r, so an accept can never coincide with a skid drain.
    always_comb begin
        accept         = in_valid && in_ready_r && !flush;
        emit           = out_valid_r && out_ready;
        load_from_skid = emit && skid_valid_r && !flush;
        load_from_in   = accept && (!out_valid_r || emit);
        load_skid      = accept && out_valid_r && !emit;

        out_valid_n  = out_valid_r;
        skid_valid_n = skid_valid_r;
        if (flush) begin
            out_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
        end else begin
            if (load_from_skid) begin
                skid_valid_n = 1'b0;
            end else if (load_from_in) begin
                out_valid_n = 1'b1;
            end else if (emit) begin
                out_valid_n = 1'b0;
            end
            if (load_skid) begin
                skid_valid_n = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r   <= '0;
            out_sel_r    <= '0;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            sel_err_r    <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_n;
            skid_valid_r <= skid_valid_n;
            in_ready_r   <= !skid_valid_n;
            if (load_from_skid) begin
                out_data_r <= skid_data_r;
                out_sel_r  <= skid_sel_r;
            end else if (load_from_in) begin
                out_data_r <= lane_data;
                out_sel_r  <= sel;
            end
            if (accept && !sel_hit) begin
                sel_err_r <= 1'b1;
            end else if (err_clr) begin
                sel_err_r <= 1'b0;
            end
        end
    end

    // NOTE: the skid payload is qualified by skid_valid_r, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_data_r <= lane_data;
            skid_sel_r  <= sel;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;
    assign out_valid = out_valid_r;
    assign sel_err   = sel_err_r;

endmodule
